// File: rtl/sfft_stream_decoder.sv
// Purpose : counts ones per lane of unary real/imag bitstreams over 2^BITWIDTH enabled cycles
// Latency : frame appears on oReal/oImg with oValid one cycle after the last sampled bit
// Backpr. : valid/ready output; a frame completing while the held frame is unaccepted is dropped (oOverrun)
//
// Ports   : iClk/iRstN (async active-low) clock and reset; iEn sample strobe; iClr sync clear;
//           iReal/iImg lane bitstreams (lane k at bit k); oReal/oImg lane k at [k*(BITWIDTH+1) +: BITWIDTH+1];
//           oValid/iReady output handshake; oOverrun sticky drop flag.
// Option  : define SFFT_DEC_BIPOLAR_EN to emit 2*count - 2^BITWIDTH instead of the plain ones count.
module sfft_stream_decoder #(
    parameter int BITWIDTH  = 8,
    parameter int NUMINPUTS = 2
) (
    input  logic                              iClk,
    input  logic                              iRstN,
    input  logic                              iEn,
    input  logic                              iClr,
    input  logic [NUMINPUTS-1:0]              iReal,
    input  logic [NUMINPUTS-1:0]              iImg,
    output logic [NUMINPUTS*(BITWIDTH+1)-1:0] oReal,
    output logic [NUMINPUTS*(BITWIDTH+1)-1:0] oImg,
    output logic                              oValid,
    input  logic                              iReady,
    output logic                              oOverrun
);
    localparam int W  = BITWIDTH + 1;
    localparam int OW = NUMINPUTS * W;
    localparam logic [BITWIDTH-1:0] CNT_MAX = '1;
    localparam logic [BITWIDTH-1:0] CNT_ONE = 1;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t              state_q, state_d;
    logic [BITWIDTH-1:0] cnt_q;
    logic [W-1:0]        acc_re_q [NUMINPUTS];
    logic [W-1:0]        acc_im_q [NUMINPUTS];
    logic [W-1:0]        sum_re   [NUMINPUTS];
    logic [W-1:0]        sum_im   [NUMINPUTS];
    logic [OW-1:0]       frame_re, frame_im;
    logic [OW-1:0]       out_re_q, out_im_q;
    logic                valid_q, ovr_q;
    logic                wrap;
    logic                out_free;

    // Lane encoding applied when a frame is captured; the accumulators always hold raw counts.
    function automatic logic [W-1:0] enc(input logic [W-1:0] c);
`ifdef SFFT_DEC_BIPOLAR_EN
        // 2*c wraps modulo 2^(BITWIDTH+1), so a full window (c = 2^BITWIDTH) lands on 1000..0.
        return {c[BITWIDTH-1:0], 1'b0} - {1'b1, {BITWIDTH{1'b0}}};
`else
        return c;
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (iEn) state_d = ACCUM;
            ACCUM:   state_d = ACCUM;
            default: state_d = IDLE;
        endcase
        if (iClr) state_d = IDLE;
    end

    // The completing cycle's own bits are part of the frame, so the frame is acc + current bit.
    always_comb begin
        frame_re = '0;
        frame_im = '0;
        for (int k = 0; k < NUMINPUTS; k++) begin
            sum_re[k] = acc_re_q[k] + {{BITWIDTH{1'b0}}, iReal[k]};
            sum_im[k] = acc_im_q[k] + {{BITWIDTH{1'b0}}, iImg[k]};
            frame_re[k*W +: W] = enc(sum_re[k]);
            frame_im[k*W +: W] = enc(sum_im[k]);
        end
    end

    assign wrap     = iEn && !iClr && (cnt_q == CNT_MAX);
    assign out_free = !valid_q || iReady;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            out_re_q <= '0;
            out_im_q <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            for (int k = 0; k < NUMINPUTS; k++) begin
                acc_re_q[k] <= '0;
                acc_im_q[k] <= '0;
            end
        end else if (iClr) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            out_re_q <= '0;
            out_im_q <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            for (int k = 0; k < NUMINPUTS; k++) begin
                acc_re_q[k] <= '0;
                acc_im_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (iEn) begin
                // Window rolls straight into the next one: no idle cycle after completion.
                cnt_q <= wrap ? '0 : cnt_q + CNT_ONE;
                for (int k = 0; k < NUMINPUTS; k++) begin
                    acc_re_q[k] <= wrap ? '0 : sum_re[k];
                    acc_im_q[k] <= wrap ? '0 : sum_im[k];
                end
            end
            if (wrap && out_free) begin
                out_re_q <= frame_re;
                out_im_q <= frame_im;
                valid_q  <= 1'b1;
            end else if (wrap) begin
                ovr_q <= 1'b1;
            end else if (valid_q && iReady) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign oReal    = out_re_q;
    assign oImg     = out_im_q;
    assign oValid   = valid_q;
    assign oOverrun = ovr_q;

endmodule

// File: tb/tb_sfft_stream_decoder.sv
// Purpose : directed + random stimulus for sfft_stream_decoder (BITWIDTH=4, NUMINPUTS=2)
// Latency : reference model updates on each rising edge; outputs sampled 1 time unit later
// Backpr. : iReady driven by the directed steps / randomly
module tb_sfft_stream_decoder;
    localparam int B = 4;
    localparam int N = 2;
    localparam int W = B + 1;
    localparam int WIN = 1 << B;

    logic            iClk = 1'b0;
    logic            iRstN = 1'b0;
    logic            iEn = 1'b0;
    logic            iClr = 1'b0;
    logic [N-1:0]    iReal = '0;
    logic [N-1:0]    iImg = '0;
    logic [N*W-1:0]  oReal, oImg;
    logic            oValid;
    logic            iReady = 1'b0;
    logic            oOverrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: number of samples taken in the current window and ones seen per lane.
    int          m_n;
    int          m_sre [N];
    int          m_sim [N];
    logic        m_vld, m_ovr;
    logic [N*W-1:0] m_ore, m_oim;

    sfft_stream_decoder #(.BITWIDTH(B), .NUMINPUTS(N)) dut (
        .iClk(iClk), .iRstN(iRstN), .iEn(iEn), .iClr(iClr),
        .iReal(iReal), .iImg(iImg), .oReal(oReal), .oImg(oImg),
        .oValid(oValid), .iReady(iReady), .oOverrun(oOverrun)
    );

    always #5 iClk = ~iClk;

    function automatic int enc(input int c);
`ifdef SFFT_DEC_BIPOLAR_EN
        return (2 * c - WIN) & ((1 << W) - 1);
`else
        return c;
`endif
    endfunction

    task automatic model_reset();
        m_n = 0;
        for (int k = 0; k < N; k++) begin
            m_sre[k] = 0;
            m_sim[k] = 0;
        end
        m_vld = 1'b0;
        m_ovr = 1'b0;
        m_ore = '0;
        m_oim = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".valid"},   32'(oValid),   32'(m_vld));
        chk({tag, ".overrun"}, 32'(oOverrun), 32'(m_ovr));
        chk({tag, ".real"},    32'(oReal),    32'(m_ore));
        chk({tag, ".img"},     32'(oImg),     32'(m_oim));
    endtask

    // Drive one cycle, advance the reference at the edge, then compare.
    task automatic step(input string tag, input logic en, input logic [N-1:0] re,
                        input logic [N-1:0] im, input logic rdy, input logic clr);
        logic [N*W-1:0] fre, fim;
        iEn = en; iReal = re; iImg = im; iReady = rdy; iClr = clr;
        @(posedge iClk);
        if (clr) begin
            model_reset();
        end else if (en) begin
            m_n++;
            for (int k = 0; k < N; k++) begin
                m_sre[k] += int'(re[k]);
                m_sim[k] += int'(im[k]);
            end
            if (m_n == WIN) begin
                fre = '0;
                fim = '0;
                for (int k = 0; k < N; k++) begin
                    fre[k*W +: W] = W'(enc(m_sre[k]));
                    fim[k*W +: W] = W'(enc(m_sim[k]));
                    m_sre[k] = 0;
                    m_sim[k] = 0;
                end
                m_n = 0;
                if (!m_vld || rdy) begin
                    m_ore = fre;
                    m_oim = fim;
                    m_vld = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_vld && rdy) begin
                m_vld = 1'b0;
            end
        end else if (m_vld && rdy) begin
            m_vld = 1'b0;
        end
        #1;
        chk_all(tag);
    endtask

    initial begin
        logic [N-1:0] r, i;
        logic [N*W-1:0] first_re;
        model_reset();

        // Reset state
        #2;
        chk_all("reset");
        @(posedge iClk); #1;
        iRstN = 1'b1;

        // One full window, lane0 real all ones
        for (int c = 0; c < WIN; c++) step("win_ones", 1'b1, 2'b01, 2'b00, 1'b1, 1'b0);
        chk("win_ones.lane0", 32'(oReal[0 +: W]), 32'(enc(16)));
        chk("win_ones.lane1", 32'(oReal[W +: W]), 32'(enc(0)));
        chk("win_ones.vld", 32'(oValid), 32'd1);

        // Lane1 toggling with 5 gap cycles interleaved
        for (int c = 0; c < WIN; c++) begin
            step("toggle", 1'b1, (c % 2 == 0) ? 2'b10 : 2'b00, 2'b00, 1'b1, 1'b0);
            if (c == 14) chk("toggle.pre_vld", 32'(oValid), 32'd0);
            if (c % 3 == 1 && c < 15)
                step("toggle_gap", 1'b0, 2'($urandom), 2'($urandom), 1'b1, 1'b0);
        end
        chk("toggle.lane1", 32'(oReal[W +: W]), 32'(enc(8)));
        chk("toggle.vld", 32'(oValid), 32'd1);

        // Two windows without acceptance -> first frame kept, overrun raised
        step("hold_start", 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
        for (int c = 0; c < WIN; c++) step("hold_w1", 1'b1, 2'($urandom), 2'($urandom), 1'b0, 1'b0);
        first_re = oReal;
        for (int c = 0; c < WIN; c++) begin
            r = 2'($urandom); i = 2'($urandom);
            step("hold_w2", 1'b1, ~first_re[1:0] ^ r, i, 1'b0, 1'b0);
        end
        chk("hold.stable", 32'(oReal), 32'(first_re));
        chk("hold.ovr", 32'(oOverrun), 32'd1);
        step("clr", 1'b1, 2'b11, 2'b11, 1'b1, 1'b1);
        chk("clr.vld", 32'(oValid), 32'd0);
        chk("clr.ovr", 32'(oOverrun), 32'd0);

        // Accept exactly on the completion cycle of the next window: no bubble
        for (int c = 0; c < WIN; c++) step("nb_w1", 1'b1, 2'($urandom), 2'($urandom), 1'b0, 1'b0);
        for (int c = 0; c < WIN; c++) begin
            step("nb_w2", 1'b1, 2'($urandom), 2'($urandom), (c == WIN - 1), 1'b0);
            chk("nb.vld", 32'(oValid), 32'd1);
        end
        chk("nb.ovr", 32'(oOverrun), 32'd0);

        // Asynchronous reset mid-window at cycle 7
        for (int c = 0; c < 7; c++) step("rst_pre", 1'b1, 2'b11, 2'b11, 1'b0, 1'b0);
        iEn = 1'b0;
        #2;
        iRstN = 1'b0;
        model_reset();
        #1;
        chk_all("async_rst");
        @(posedge iClk); #1;
        iRstN = 1'b1;
        for (int c = 0; c < WIN; c++) begin
            step("post_rst", 1'b1, 2'b11, 2'b01, 1'b0, 1'b0);
            if (c == WIN - 2) chk("post_rst.pre_vld", 32'(oValid), 32'd0);
        end
        chk("post_rst.lane0", 32'(oReal[0 +: W]), 32'(enc(16)));

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            step("rand", ($urandom_range(0, 9) < 7), 2'($urandom), 2'($urandom),
                 1'($urandom), ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
